// File: rtl/ifetch_pc_queue_if.sv
// Handshake bundle for ifetch_pc_queue: redirect, fetch request/response and decode output.
// The fetch unit uses the master view; the memory/decode side uses the slave view.
interface ifetch_pc_queue_if #(
    parameter int unsigned PC_W    = 25,
    parameter int unsigned INSTR_W = 32
);
    logic               redirect_valid_i;
    logic [PC_W-1:0]    redirect_pc_i;
    logic               req_valid_o;
    logic [PC_W-1:0]    req_addr_o;
    logic               req_ready_i;
    logic               resp_valid_i;
    logic [INSTR_W-1:0] resp_data_i;
    logic               out_valid_o;
    logic [PC_W-1:0]    out_pc_o;
    logic [INSTR_W-1:0] out_instr_o;
    logic               out_ready_i;

    modport master (
        input  redirect_valid_i, redirect_pc_i, req_ready_i, resp_valid_i, resp_data_i,
        input  out_ready_i,
        output req_valid_o, req_addr_o, out_valid_o, out_pc_o, out_instr_o
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i, req_ready_i, resp_valid_i, resp_data_i,
        output out_ready_i,
        input  req_valid_o, req_addr_o, out_valid_o, out_pc_o, out_instr_o
    );
endinterface

// File: rtl/ifetch_pc_queue.sv
// Instruction-fetch front end: warm-up hold, sequential PC issue, branch redirect with
// discard of stale responses, and an in-order {pc, instr} buffer towards decode.
module ifetch_pc_queue #(
    parameter int unsigned     PC_W          = 25,
    parameter int unsigned     INSTR_W       = 32,
    parameter logic [PC_W-1:0] RESET_VEC     = '0,
    parameter int unsigned     WARMUP_CYCLES = 4,
    parameter int unsigned     STEP          = 1,
    parameter int unsigned     DEPTH         = 4
) (
    input logic               clk,
    input logic               rst_n,
    ifetch_pc_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Discards only drain as memory answers, so give them headroom beyond DEPTH.
    localparam int unsigned DW = CW + 4;

    localparam logic [0:0] StWarmup = 1'b0;
    localparam logic [0:0] StRun    = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [31:0]     warm_cnt_q, warm_cnt_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   live_q, live_d;
    logic [CW-1:0]   buf_cnt_q, buf_cnt_d;
    logic [DW-1:0]   disc_q, disc_d;
    logic [AW-1:0]   pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic [AW-1:0]   buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;

    logic [PC_W-1:0]    pcq_mem_q   [DEPTH];
    logic [PC_W-1:0]    buf_pc_q    [DEPTH];
    logic [INSTR_W-1:0] buf_instr_q [DEPTH];

    logic [CW:0] live_total;
    logic        req_valid, issue, resp_drop, resp_keep, buf_push, buf_pop, redirect;

    // live_q counts only in-flight requests whose responses will be kept (P - D).
    assign live_total = {1'b0, live_q} + {1'b0, buf_cnt_q};
    assign redirect   = bus.redirect_valid_i;
    assign req_valid  = (state_q == StRun) && !redirect && (live_total < (CW + 1)'(DEPTH));
    assign issue      = req_valid && bus.req_ready_i;
    assign resp_drop  = bus.resp_valid_i && (disc_q != '0);
    assign resp_keep  = bus.resp_valid_i && (disc_q == '0);
    assign buf_push   = resp_keep && !redirect;
    assign buf_pop    = (buf_cnt_q != '0) && bus.out_ready_i && !redirect;

    assign bus.req_valid_o = req_valid;
    assign bus.req_addr_o  = fetch_pc_q;
    assign bus.out_valid_o = (buf_cnt_q != '0);
    assign bus.out_pc_o    = (buf_cnt_q != '0) ? buf_pc_q[buf_rd_q] : '0;
    assign bus.out_instr_o = (buf_cnt_q != '0) ? buf_instr_q[buf_rd_q] : '0;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        fetch_pc_d = fetch_pc_q;
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;
        buf_wr_d   = buf_wr_q;
        buf_rd_d   = buf_rd_q;

        if (state_q == StWarmup) begin
            warm_cnt_d = warm_cnt_q + 32'd1;
            if (warm_cnt_q + 32'd1 >= 32'(WARMUP_CYCLES)) begin
                state_d = StRun;
            end
        end

        if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_W'(STEP);
            pcq_wr_d   = pcq_wr_q + AW'(1);
        end
        if (resp_keep) begin
            pcq_rd_d = pcq_rd_q + AW'(1);
        end
        if (buf_push) begin
            buf_wr_d = buf_wr_q + AW'(1);
        end
        if (buf_pop) begin
            buf_rd_d = buf_rd_q + AW'(1);
        end

        live_d    = live_q + CW'(issue) - CW'(resp_keep);
        disc_d    = disc_q - DW'(resp_drop);
        buf_cnt_d = buf_cnt_q + CW'(buf_push) - CW'(buf_pop);

        // No issue can happen in a redirect cycle, so live_d is exactly what remains in flight.
        if (redirect) begin
            fetch_pc_d = bus.redirect_pc_i;
            disc_d     = disc_d + DW'(live_d);
            live_d     = '0;
            pcq_rd_d   = pcq_wr_q;
            buf_cnt_d  = '0;
            buf_rd_d   = buf_wr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StWarmup;
            warm_cnt_q <= '0;
            fetch_pc_q <= RESET_VEC;
            live_q     <= '0;
            buf_cnt_q  <= '0;
            disc_q     <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            fetch_pc_q <= fetch_pc_d;
            live_q     <= live_d;
            buf_cnt_q  <= buf_cnt_d;
            disc_q     <= disc_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && issue) begin
            pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (rst_n && buf_push) begin
            buf_pc_q[buf_wr_q]    <= pcq_mem_q[pcq_rd_q];
            buf_instr_q[buf_wr_q] <= bus.resp_data_i;
        end
    end
endmodule

// File: tb/tb_ifetch_pc_queue.sv
// Scoreboard bench for ifetch_pc_queue: a latency-programmable memory model feeds responses,
// accepted addresses are queued as expected decode output and compared on every pop.
module tb_ifetch_pc_queue;
    logic clk = 1'b0;
    logic rst_n, rst1_n;
    always #5 clk = ~clk;

    ifetch_pc_queue_if #(.PC_W(25), .INSTR_W(32)) bus0 ();
    ifetch_pc_queue_if #(.PC_W(4), .INSTR_W(32))  bus1 ();

    ifetch_pc_queue dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.master)
    );

    ifetch_pc_queue #(
        .PC_W          (4),
        .INSTR_W       (32),
        .RESET_VEC     (4'hC),
        .WARMUP_CYCLES (0),
        .STEP          (2),
        .DEPTH         (4)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1.master)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [24:0] pc);
        return 32'hA500_0000 ^ {7'd0, pc};
    endfunction

    // Memory model and scoreboard state.
    int          cyc = 0;
    int          lat = 1;
    int          next_due = 0;
    logic [24:0] exp_q[$];
    logic [24:0] mem_q[$];
    int          due_q[$];
    logic [24:0] pop_log[$];
    int          acc_cnt = 0;
    logic [24:0] last_acc = '0;
    int          resp_in_redir = 0;

    initial begin
        logic [24:0] e;
        logic [24:0] a;
        int          d;
        bus0.resp_valid_i = 1'b0;
        bus0.resp_data_i  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                mem_q.delete();
                due_q.delete();
                next_due          = 0;
                acc_cnt           = 0;
                bus0.resp_valid_i = 1'b0;
            end else begin
                if (bus0.req_valid_o && bus0.req_ready_i) begin
                    exp_q.push_back(bus0.req_addr_o);
                    mem_q.push_back(bus0.req_addr_o);
                    d = cyc + lat;
                    if (d < next_due) d = next_due;
                    next_due = d;
                    due_q.push_back(d);
                    acc_cnt++;
                    last_acc = bus0.req_addr_o;
                end
                if (bus0.out_valid_o && bus0.out_ready_i && !bus0.redirect_valid_i) begin
                    pop_log.push_back(bus0.out_pc_o);
                    if (exp_q.size() == 0) begin
                        check_eq("pop_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("pop_pc", bus0.out_pc_o, e);
                        check_eq("pop_instr", bus0.out_instr_o, instr_of(e));
                    end
                end
                if (bus0.redirect_valid_i) exp_q.delete();
                if (mem_q.size() > 0 && due_q[0] <= cyc) begin
                    a = mem_q.pop_front();
                    void'(due_q.pop_front());
                    bus0.resp_valid_i = 1'b1;
                    bus0.resp_data_i  = instr_of(a);
                end else begin
                    bus0.resp_valid_i = 1'b0;
                end
                if (bus0.redirect_valid_i && bus0.resp_valid_i) resp_in_redir++;
            end
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus0.req_ready_i      = 1'b0;
        bus0.out_ready_i      = 1'b0;
        bus0.redirect_valid_i = 1'b0;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(4);
    endtask

    initial begin
        bit found;
        int forbidden;
        rst_n = 1'b0;
        rst1_n = 1'b0;
        bus0.redirect_valid_i = 1'b0;
        bus0.redirect_pc_i    = '0;
        bus0.req_ready_i      = 1'b0;
        bus0.out_ready_i      = 1'b0;
        bus1.redirect_valid_i = 1'b0;
        bus1.redirect_pc_i    = '0;
        bus1.req_ready_i      = 1'b1;
        bus1.resp_valid_i     = 1'b0;
        bus1.resp_data_i      = '0;
        bus1.out_ready_i      = 1'b0;

        // Reset state and warm-up
        step(5);
        check_eq("rst_req_valid", bus0.req_valid_o, 0);
        check_eq("rst_req_addr", bus0.req_addr_o, 0);
        check_eq("rst_out_valid", bus0.out_valid_o, 0);
        check_eq("rst_out_pc", bus0.out_pc_o, 0);
        check_eq("rst_out_instr", bus0.out_instr_o, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check_eq("warm_req_valid", bus0.req_valid_o, (i == 4));
        end
        check_eq("warm_req_addr", bus0.req_addr_o, 0);
        lat = 1;
        bus0.req_ready_i = 1'b1;
        bus0.out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq("seq_req_valid", bus0.req_valid_o, 1);
            check_eq("seq_req_addr", bus0.req_addr_o, i);
            step(1);
        end

        // Backpressure
        do_reset();
        bus0.req_ready_i = 1'b1;
        step(8);
        check_eq("bp_accepted", acc_cnt, 4);
        check_eq("bp_req_valid", bus0.req_valid_o, 0);
        check_eq("bp_out_valid", bus0.out_valid_o, 1);
        check_eq("bp_out_pc", bus0.out_pc_o, 0);
        check_eq("bp_out_instr", bus0.out_instr_o, instr_of(25'd0));
        bus0.out_ready_i = 1'b1;
        step(1);
        bus0.out_ready_i = 1'b0;
        step(5);
        check_eq("bp_accepted_after_pop", acc_cnt, 5);
        check_eq("bp_new_addr", last_acc, 4);
        bus0.out_ready_i = 1'b1;
        step(12);

        // Redirect with requests in flight, 3-cycle memory
        do_reset();
        lat = 3;
        bus0.req_ready_i = 1'b1;
        bus0.out_ready_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus0.req_valid_o && bus0.req_addr_o == 25'd6) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        check_eq("rd_reach_addr6", found, 1);
        step(1);
        bus0.redirect_valid_i = 1'b1;
        bus0.redirect_pc_i    = 25'h100;
        bus0.out_ready_i      = 1'b0;
        pop_log.delete();
        #1;
        check_eq("rd_req_valid_in_redirect", bus0.req_valid_o, 0);
        step(1);
        bus0.redirect_valid_i = 1'b0;
        #1;
        check_eq("rd_next_req_valid", bus0.req_valid_o, 1);
        check_eq("rd_next_req_addr", bus0.req_addr_o, 25'h100);
        bus0.out_ready_i = 1'b1;
        step(25);
        forbidden = 0;
        foreach (pop_log[i]) if (pop_log[i] == 25'd5 || pop_log[i] == 25'd6) forbidden++;
        check_eq("rd_stale_pops", forbidden, 0);
        check_eq("rd_pops_seen", pop_log.size() >= 2, 1);
        if (pop_log.size() >= 2) begin
            check_eq("rd_first_pop", pop_log[0], 25'h100);
            check_eq("rd_second_pop", pop_log[1], 25'h101);
        end

        // Redirect coincident with a response and a pop
        do_reset();
        lat = 1;
        bus0.req_ready_i = 1'b1;
        step(2);
        check_eq("co_out_valid_before", bus0.out_valid_o, 1);
        check_eq("co_out_pc_before", bus0.out_pc_o, 0);
        resp_in_redir = 0;
        pop_log.delete();
        bus0.redirect_valid_i = 1'b1;
        bus0.redirect_pc_i    = 25'h100;
        bus0.out_ready_i      = 1'b1;
        bus0.req_ready_i      = 1'b0;
        step(1);
        bus0.redirect_valid_i = 1'b0;
        #1;
        check_eq("co_resp_coincident", resp_in_redir, 1);
        check_eq("co_out_valid_after", bus0.out_valid_o, 0);
        check_eq("co_req_valid", bus0.req_valid_o, 1);
        check_eq("co_req_addr", bus0.req_addr_o, 25'h100);
        bus0.req_ready_i = 1'b1;
        step(10);
        check_eq("co_pops_seen", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) check_eq("co_first_pop", pop_log[0], 25'h100);

        // Mid-operation reset with three buffered and one in flight
        do_reset();
        lat = 1;
        bus0.req_ready_i = 1'b1;
        step(4);
        check_eq("mr_out_valid_before", bus0.out_valid_o, 1);
        check_eq("mr_req_valid_before", bus0.req_valid_o, 0);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_eq("mr_req_valid", bus0.req_valid_o, 0);
        check_eq("mr_req_addr", bus0.req_addr_o, 0);
        check_eq("mr_out_valid", bus0.out_valid_o, 0);
        check_eq("mr_out_pc", bus0.out_pc_o, 0);
        check_eq("mr_out_instr", bus0.out_instr_o, 0);
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check_eq("mr_warm_req_valid", bus0.req_valid_o, (i == 4));
        end
        bus0.req_ready_i = 1'b0;

        // Wrap and step on the narrow instance
        check_eq("wr_rst_req_valid", bus1.req_valid_o, 0);
        check_eq("wr_rst_req_addr", bus1.req_addr_o, 4'hC);
        rst1_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ea;
            ea = 4'hC + 4'(2 * i);
            step(1);
            check_eq("wr_req_valid", bus1.req_valid_o, 1);
            check_eq("wr_req_addr", bus1.req_addr_o, ea);
        end
        step(1);
        check_eq("wr_full_req_valid", bus1.req_valid_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
